// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin owner of the shared memory bus for N_CPU Cpus.
// One transfer in flight at a time; a stalled memory cycle aborts after TMO cycles.
module cpu_bus_arbiter #(
    parameter int N_CPU  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO    = 255
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [N_CPU-1:0]        cpu_read_q,
    input  logic [N_CPU-1:0]        cpu_write_q,
    input  logic [N_CPU*ADDR_W-1:0] cpu_addr,
    input  logic [N_CPU*DATA_W-1:0] cpu_wdata,
    output logic [N_CPU-1:0]        cpu_read_dn,
    output logic [N_CPU-1:0]        cpu_write_dn,
    output logic [N_CPU-1:0]        cpu_err,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic [N_CPU-1:0]        cpu_bus_busy,
    output logic                    mem_read_q,
    output logic                    mem_write_q,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_read_dn,
    input  logic                    mem_write_dn
);

    localparam int IDX_W = $clog2(N_CPU);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_gnt;
    logic [IDX_W-1:0]    r_rr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_is_wr;
    logic                r_err;
    logic [15:0]         r_timer;

    logic [N_CPU-1:0]    w_req;
    logic [N_CPU-1:0]    w_rot;
    logic                w_hit;
    logic [IDX_W-1:0]    w_ofs;
    logic [IDX_W:0]      w_sum;
    logic [IDX_W-1:0]    w_sel;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_wr;
    logic                w_done;
    logic                w_tmo;
    logic [N_CPU-1:0]    w_gnt_oh;
    logic [IDX_W-1:0]    w_rr_nxt;

    assign w_req = cpu_read_q | cpu_write_q;

    // Rotate so bit 0 is the Cpu at rr_ptr; first set bit is the winner's offset.
    assign w_rot = N_CPU'({w_req, w_req} >> r_rr);

    always_comb begin
        w_hit = 1'b0;
        w_ofs = '0;
        for (int i = N_CPU - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_hit = 1'b1;
                w_ofs = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, r_rr} + {1'b0, w_ofs};
    assign w_sel = (w_sum >= (IDX_W+1)'(N_CPU)) ?
                   IDX_W'(w_sum - (IDX_W+1)'(N_CPU)) : w_sum[IDX_W-1:0];

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wr    = 1'b0;
        for (int i = 0; i < N_CPU; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_addr  = cpu_addr[i*ADDR_W +: ADDR_W];
                w_wdata = cpu_wdata[i*DATA_W +: DATA_W];
                w_wr    = cpu_write_q[i];
            end
        end
    end

    assign w_done   = r_is_wr ? mem_write_dn : mem_read_dn;
    assign w_tmo    = (r_timer == 16'(TMO - 1));
    assign w_gnt_oh = {{(N_CPU-1){1'b0}}, 1'b1} << r_gnt;
    assign w_rr_nxt = (r_gnt == IDX_W'(N_CPU - 1)) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_hit) w_next = S_XFER;
            S_XFER:  if (w_done || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A dn in the last timer cycle completes normally: err only when no dn.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_gnt   <= '0;
            r_rr    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_gnt   <= w_sel;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_is_wr <= w_wr;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_timer <= '0;
                    end
                end
                S_XFER: begin
                    r_timer <= r_timer + 16'd1;
                    if (w_done) begin
                        if (!r_is_wr) r_rdata <= mem_rdata;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr <= w_rr_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_read_dn  = '0;
        cpu_write_dn = '0;
        cpu_err      = '0;
        cpu_rdata    = '0;
        cpu_bus_busy = '0;
        mem_read_q   = 1'b0;
        mem_write_q  = 1'b0;
        unique case (r_state)
            S_XFER: begin
                cpu_bus_busy = ~w_gnt_oh;
                mem_read_q   = !r_is_wr;
                mem_write_q  = r_is_wr;
            end
            S_RESP: begin
                cpu_bus_busy = ~w_gnt_oh;
                if (r_err) begin
                    cpu_err = w_gnt_oh;
                end else if (r_is_wr) begin
                    cpu_write_dn = w_gnt_oh;
                end else begin
                    cpu_read_dn = w_gnt_oh;
                    cpu_rdata   = r_rdata;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed and randomized checks of cpu_bus_arbiter
// against a queue/arithmetic round-robin model (N_CPU=4, TMO=8).
module tb_cpu_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [N-1:0]    rq, wq;
    logic [AW-1:0]   a_arr [N];
    logic [DW-1:0]   d_arr [N];
    logic [N*AW-1:0] cpu_addr;
    logic [N*DW-1:0] cpu_wdata;
    logic [N-1:0]    cpu_read_dn, cpu_write_dn, cpu_err, cpu_bus_busy;
    logic [DW-1:0]   cpu_rdata;
    logic            mem_read_q, mem_write_q;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_read_dn, mem_write_dn;

    int errors = 0;
    int checks = 0;
    int m_rr = 0;

    always #5 clk = ~clk;

    always_comb begin
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < N; i++) begin
            cpu_addr[i*AW +: AW]  = a_arr[i];
            cpu_wdata[i*DW +: DW] = d_arr[i];
        end
    end

    cpu_bus_arbiter #(.N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_read_q(rq), .cpu_write_q(wq),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read_dn(cpu_read_dn), .cpu_write_dn(cpu_write_dn),
        .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .cpu_bus_busy(cpu_bus_busy),
        .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_read_dn(mem_read_dn), .mem_write_dn(mem_write_dn)
    );

    // Round-robin rule: first requester at or after rr, wrapping.
    function automatic int pick(input logic [N-1:0] req, input int rr);
        for (int k = 0; k < N; k++)
            if (req[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        rq = '0;
        wq = '0;
        mem_read_dn = 1'b0;
        mem_write_dn = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst_b = 1'b1;
        m_rr = 0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_read_q || mem_write_q) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        logic [113:0] outs;
        do_reset();
        outs = {cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, cpu_bus_busy,
                mem_read_q, mem_write_q, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
        a_arr[1] = 32'h44;
        rq[1] = 1'b1;
        wait_strobe(ok);
        tick();
        #2 rst_b = 1'b0;
        #1;
        outs = {cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, cpu_bus_busy,
                mem_read_q, mem_write_q, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got %h want 0", outs);
        end
        rq = 4'b1010;
        tick();
        rst_b = 1'b1;
        m_rr = 0;
        wait_strobe(ok);
        checks++;
        if (!ok || cpu_bus_busy !== 4'b1101) begin
            errors++;
            $display("FAIL reset_first_grant: busy %b want 1101", cpu_bus_busy);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        a_arr[2] = 32'h100;
        rq[2] = 1'b1;
        tick();
        checks++;
        if ({mem_read_q, mem_write_q, mem_addr, cpu_bus_busy} !==
            {2'b10, 32'h100, 4'b1011}) begin
            errors++;
            $display("FAIL read_strobe: rq=%b wq=%b addr=%h busy=%b want 1 0 100 1011",
                     mem_read_q, mem_write_q, mem_addr, cpu_bus_busy);
        end
        tick();
        mem_read_dn = 1'b1;
        mem_rdata = 32'hDEAD;
        tick();
        mem_read_dn = 1'b0;
        checks++;
        if ({cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, mem_read_q} !==
            {4'b0100, 4'b0, 4'b0, 32'hDEAD, 1'b0}) begin
            errors++;
            $display("FAIL read_resp: rdn=%b wdn=%b err=%b rdata=%h mrq=%b want 0100 0 0 dead 0",
                     cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, mem_read_q);
        end
        rq[2] = 1'b0;
        tick();
        checks++;
        if ({cpu_read_dn, cpu_bus_busy} !== 8'h00) begin
            errors++;
            $display("FAIL read_idle: rdn=%b busy=%b want 0 0", cpu_read_dn, cpu_bus_busy);
        end
    endtask

    task automatic test_write();
        do_reset();
        a_arr[1] = 32'h20;
        d_arr[1] = 32'h55AA;
        wq[1] = 1'b1;
        rq[1] = 1'b1;
        tick();
        checks++;
        if ({mem_write_q, mem_read_q, mem_addr, mem_wdata} !==
            {2'b10, 32'h20, 32'h55AA}) begin
            errors++;
            $display("FAIL write_strobe: wq=%b rq=%b addr=%h wdata=%h want 1 0 20 55aa",
                     mem_write_q, mem_read_q, mem_addr, mem_wdata);
        end
        d_arr[1] = 32'h1234;
        a_arr[1] = 32'h99;
        mem_read_dn = 1'b1;
        tick();
        mem_read_dn = 1'b0;
        checks++;
        if ({mem_write_q, mem_wdata, mem_addr, cpu_read_dn, cpu_write_dn} !==
            {1'b1, 32'h55AA, 32'h20, 8'h00}) begin
            errors++;
            $display("FAIL write_hold: wq=%b wdata=%h addr=%h rdn=%b wdn=%b want 1 55aa 20 0 0",
                     mem_write_q, mem_wdata, mem_addr, cpu_read_dn, cpu_write_dn);
        end
        mem_write_dn = 1'b1;
        mem_rdata = 32'hFFFF;
        tick();
        mem_write_dn = 1'b0;
        checks++;
        if ({cpu_write_dn, cpu_read_dn, cpu_err, cpu_rdata} !==
            {4'b0010, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL write_resp: wdn=%b rdn=%b err=%b rdata=%h want 0010 0 0 0",
                     cpu_write_dn, cpu_read_dn, cpu_err, cpu_rdata);
        end
        rq = '0;
        wq = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_g;
        int rr;
        int g;
        do_reset();
        rq = 4'b1011;
        for (int c = 0; c < 100 && got.size() < 6; c++) begin
            tick();
            mem_read_dn = 1'b0;
            if (mem_read_q) begin
                g = -1;
                for (int i = 0; i < N; i++) if (!cpu_bus_busy[i]) g = i;
                got.push_back(g);
                mem_read_dn = 1'b1;
            end
        end
        tick();
        mem_read_dn = 1'b0;
        rq = '0;
        tick();
        tick();
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 6", got.size());
        end
        rr = 0;
        for (int j = 0; j < got.size(); j++) begin
            exp_g = pick(4'b1011, rr);
            rr = (exp_g + 1) % N;
            checks++;
            if (got[j] != exp_g) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", j, got[j], exp_g);
            end
            if (j > 0) begin
                checks++;
                if (got[j] == got[j-1]) begin
                    errors++;
                    $display("FAIL rr_repeat[%0d]: got %0d twice want distinct", j, got[j]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        do_reset();
        rq = 4'b1001;
        wait_strobe(ok);
        checks++;
        if (!ok || cpu_bus_busy !== 4'b1110) begin
            errors++;
            $display("FAIL tmo_grant: busy %b want 1110", cpu_bus_busy);
        end
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            cnt++;
            if (|(cpu_read_dn | cpu_write_dn | cpu_err)) break;
        end
        checks++;
        if (cnt != TMO || {cpu_err, cpu_read_dn, mem_read_q, mem_write_q} !==
            {4'b0001, 4'b0, 2'b0}) begin
            errors++;
            $display("FAIL tmo_err: cycles=%0d err=%b rdn=%b mrq=%b want %0d 0001 0 0",
                     cnt, cpu_err, cpu_read_dn, mem_read_q, TMO);
        end
        rq[0] = 1'b0;
        wait_strobe(ok);
        checks++;
        if (!ok || cpu_bus_busy !== 4'b0111) begin
            errors++;
            $display("FAIL tmo_next: busy %b want 0111", cpu_bus_busy);
        end
        mem_read_dn = 1'b1;
        tick();
        mem_read_dn = 1'b0;
        rq = '0;
        tick();
    endtask

    task automatic test_race();
        bit ok;
        do_reset();
        rq[2] = 1'b1;
        wait_strobe(ok);
        for (int j = 0; j < TMO - 1; j++) tick();
        mem_read_dn = 1'b1;
        mem_rdata = 32'hBEEF;
        tick();
        mem_read_dn = 1'b0;
        checks++;
        if ({cpu_read_dn, cpu_err, cpu_rdata} !== {4'b0100, 4'b0, 32'hBEEF}) begin
            errors++;
            $display("FAIL race: rdn=%b err=%b rdata=%h want 0100 0 beef",
                     cpu_read_dn, cpu_err, cpu_rdata);
        end
        rq[2] = 1'b0;
        tick();
        rq[0] = 1'b1;
        wait_strobe(ok);
        tick();
        #2 rst_b = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({cpu_read_dn, cpu_write_dn, cpu_err, mem_read_q, mem_write_q} !== '0) begin
                errors++;
                $display("FAIL reset_xfer[%0d]: rdn=%b wdn=%b err=%b mrq=%b mwq=%b want 0",
                         c, cpu_read_dn, cpu_write_dn, cpu_err, mem_read_q, mem_write_q);
            end
            tick();
        end
        rq = '0;
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] newm;
        logic [N-1:0] oh;
        logic [DW-1:0] rd;
        int kind, g, k, cnt, exp_cnt;
        bit ok, seen, exp_wr;
        do_reset();
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            newm = N'($urandom_range(0, 15)) & ~pend;
            if ((pend | newm) == '0) newm[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (newm[i]) begin
                    a_arr[i] = $urandom;
                    d_arr[i] = $urandom;
                    kind = $urandom_range(0, 2);
                    rq[i] = (kind != 1);
                    wq[i] = (kind != 0);
                    pend[i] = 1'b1;
                end
            end
            g = pick(pend, m_rr);
            exp_wr = wq[g];
            oh = '0;
            oh[g] = 1'b1;
            wait_strobe(ok);
            checks++;
            if (!ok || cpu_bus_busy !== ~oh || {mem_write_q, mem_read_q} !== {exp_wr, !exp_wr}
                || mem_addr !== a_arr[g] || (exp_wr && mem_wdata !== d_arr[g])) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: busy=%b wq=%b rq=%b addr=%h wdata=%h want busy=%b wr=%b addr=%h wdata=%h",
                         t, cpu_bus_busy, mem_write_q, mem_read_q, mem_addr, mem_wdata,
                         ~oh, exp_wr, a_arr[g], d_arr[g]);
            end
            k = $urandom_range(0, TMO + 2);
            rd = $urandom;
            cnt = 0;
            seen = 1'b0;
            for (int j = 0; j < TMO + 5 && !seen; j++) begin
                if (j == k && k < TMO) begin
                    mem_read_dn = !exp_wr;
                    mem_write_dn = exp_wr;
                    mem_rdata = rd;
                end
                tick();
                cnt++;
                mem_read_dn = 1'b0;
                mem_write_dn = 1'b0;
                seen = |(cpu_read_dn | cpu_write_dn | cpu_err);
            end
            exp_cnt = (k < TMO) ? k + 1 : TMO;
            checks++;
            if (!seen || cnt != exp_cnt) begin
                errors++;
                $display("FAIL rnd_latency[%0d]: cycles=%0d want %0d", t, cnt, exp_cnt);
            end
            checks++;
            if (k >= TMO) begin
                if ({cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata} !== {8'h00, oh, 32'h0}) begin
                    errors++;
                    $display("FAIL rnd_err[%0d]: rdn=%b wdn=%b err=%b rdata=%h want err=%b",
                             t, cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, oh);
                end
            end else if (exp_wr) begin
                if ({cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata} !== {4'b0, oh, 4'b0, 32'h0}) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d]: rdn=%b wdn=%b err=%b rdata=%h want wdn=%b",
                             t, cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, oh);
                end
            end else begin
                if ({cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata} !== {oh, 8'h00, rd}) begin
                    errors++;
                    $display("FAIL rnd_rd[%0d]: rdn=%b wdn=%b err=%b rdata=%h want rdn=%b rdata=%h",
                             t, cpu_read_dn, cpu_write_dn, cpu_err, cpu_rdata, oh, rd);
                end
            end
            rq[g] = 1'b0;
            wq[g] = 1'b0;
            pend[g] = 1'b0;
            m_rr = (g + 1) % N;
        end
        rq = '0;
        wq = '0;
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        rq = '0;
        wq = '0;
        mem_read_dn = 1'b0;
        mem_write_dn = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
